// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: BRU resolution bypass, BTB entry layout,
// 2-bit counter encodings and small helpers.
package branch_predictor_pkg;

    typedef struct packed {
        logic        branch_in_exec;
        logic        branch_result;
        logic [31:0] branch_ins_PC;
        logic [31:0] jump_PC;
        logic        is_ret;
        logic        is_call;
    } BRU_BP_bypass_t;

    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] STRONG_T  = 2'b11;

    // Tag field is wide enough for the smallest table; unused upper bits stay zero.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        logic [1:0]  ctr;
        logic        is_ret;
    } btb_entry_t;

    function automatic logic [29:0] pc_tag(input logic [31:0] pc, input int unsigned idx_bits);
        return 30'(pc >> (idx_bits + 2));
    endfunction

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == STRONG_T) ? STRONG_T : ctr + 2'b01;
        return (ctr == STRONG_NT) ? STRONG_NT : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/branch_predictor_ras.sv
// Return-address stack: circular buffer that overwrites the oldest entry when full
// and ignores pops when empty. Push wins over pop.
module ras #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_addr,
    output logic [31:0] top,
    output logic        empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [31:0]   stack_q [DEPTH];
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] top_idx;
    logic [PW:0]   count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else if (push) begin
            stack_q[ptr_q] <= push_addr;
            ptr_q          <= ptr_q + 1'b1;
            if (count_q != (PW+1)'(DEPTH))
                count_q <= count_q + 1'b1;
        end else if (pop && count_q != '0) begin
            ptr_q   <= ptr_q - 1'b1;
            count_q <= count_q - 1'b1;
        end
    end

    assign top_idx = ptr_q - 1'b1;
    assign top     = stack_q[top_idx];
    assign empty   = (count_q == '0);

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB/BHT branch predictor with zero-latency lookup.
// Optional return-address stack enabled by macro BP_RAS_EN.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 64,
    parameter int unsigned RAS_DEPTH   = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [31:0]    fetch_PC,
    output logic           predict_taken,
    output logic [31:0]    predict_PC,
    input  BRU_BP_bypass_t BRU_BP_bypass
);

    localparam int unsigned IDX = $clog2(BTB_ENTRIES);

    btb_entry_t     table_q [BTB_ENTRIES];
    btb_entry_t     rd_entry;
    btb_entry_t     wr_entry;
    logic [IDX-1:0] rd_idx;
    logic [IDX-1:0] wr_idx;
    logic [29:0]    rd_tag;
    logic [29:0]    wr_tag;
    logic           rd_hit;
    logic           wr_hit;

    assign rd_idx   = fetch_PC[2+IDX-1:2];
    assign rd_tag   = pc_tag(fetch_PC, IDX);
    assign rd_entry = table_q[rd_idx];
    assign rd_hit   = rd_entry.valid && (rd_entry.tag == rd_tag);

    assign wr_idx   = BRU_BP_bypass.branch_ins_PC[2+IDX-1:2];
    assign wr_tag   = pc_tag(BRU_BP_bypass.branch_ins_PC, IDX);
    assign wr_entry = table_q[wr_idx];
    assign wr_hit   = wr_entry.valid && (wr_entry.tag == wr_tag);

    // Only valid bits are reset; tags/targets are qualified by valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++)
                table_q[i].valid <= 1'b0;
        end else if (BRU_BP_bypass.branch_in_exec) begin
            if (wr_hit) begin
                table_q[wr_idx].ctr    <= ctr_step(wr_entry.ctr, BRU_BP_bypass.branch_result);
                table_q[wr_idx].is_ret <= BRU_BP_bypass.is_ret;
                if (BRU_BP_bypass.branch_result)
                    table_q[wr_idx].target <= BRU_BP_bypass.jump_PC;
            end else if (BRU_BP_bypass.branch_result) begin
                table_q[wr_idx] <= '{valid:  1'b1,
                                     tag:    wr_tag,
                                     target: BRU_BP_bypass.jump_PC,
                                     ctr:    WEAK_T,
                                     is_ret: BRU_BP_bypass.is_ret};
            end
        end
    end

`ifdef BP_RAS_EN
    logic [31:0] ras_top;
    logic        ras_empty;
    logic        ras_push;
    logic        ras_pop;

    assign ras_push = BRU_BP_bypass.branch_in_exec && BRU_BP_bypass.is_call;
    assign ras_pop  = BRU_BP_bypass.branch_in_exec && BRU_BP_bypass.is_ret && !BRU_BP_bypass.is_call;

    ras #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_addr (BRU_BP_bypass.branch_ins_PC + 32'd8),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`else
    logic unused_call;
    assign unused_call = BRU_BP_bypass.is_call;
`endif

    always_comb begin
        predict_taken = rd_hit && (rd_entry.ctr[1] || rd_entry.is_ret);
        predict_PC    = fetch_PC + 32'd8;
        if (predict_taken)
            predict_PC = rd_entry.target;
`ifdef BP_RAS_EN
        if (rd_hit && rd_entry.is_ret && !ras_empty)
            predict_PC = ras_top;
`endif
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// traffic against a table/queue reference model. Honours BP_RAS_EN like the RTL.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    localparam int unsigned N = 64;
    localparam int unsigned D = 8;
    localparam logic [31:0] PC_A = 32'h8000_1000;
    localparam logic [31:0] PC_B = 32'h8001_1000;
    localparam logic [31:0] PC_R = 32'h8000_4040;

    logic           clk = 1'b0;
    logic           reset;
    logic [31:0]    fetch_PC;
    logic           predict_taken;
    logic [31:0]    predict_PC;
    BRU_BP_bypass_t bp;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_predictor #(.BTB_ENTRIES(N), .RAS_DEPTH(D)) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_PC      (fetch_PC),
        .predict_taken (predict_taken),
        .predict_PC    (predict_PC),
        .BRU_BP_bypass (bp)
    );

    // Reference model: plain arrays for the table, a queue for the return stack.
    bit          m_valid  [N];
    logic [31:0] m_tag    [N];
    logic [31:0] m_target [N];
    int          m_ctr    [N];
    bit          m_ret    [N];
    logic [31:0] m_ras    [$];

    function automatic void model_reset();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_ras.delete();
    endfunction

    function automatic void model_predict(input logic [31:0] pc, output logic t, output logic [31:0] p);
        int unsigned i;
        bit hit;
        i   = (pc / 4) % N;
        hit = m_valid[i] && (m_tag[i] == pc / (4 * N));
        t   = hit && (m_ctr[i] >= 2 || m_ret[i]);
        p   = t ? m_target[i] : pc + 32'd8;
`ifdef BP_RAS_EN
        if (hit && m_ret[i] && m_ras.size() > 0) p = m_ras[$];
`endif
    endfunction

    function automatic void model_update(input BRU_BP_bypass_t b);
        int unsigned i;
        bit hit;
        if (!b.branch_in_exec) return;
        i   = (b.branch_ins_PC / 4) % N;
        hit = m_valid[i] && (m_tag[i] == b.branch_ins_PC / (4 * N));
        if (hit) begin
            if (b.branch_result) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            else                 m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            if (b.branch_result) m_target[i] = b.jump_PC;
            m_ret[i] = b.is_ret;
        end else if (b.branch_result) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = b.branch_ins_PC / (4 * N);
            m_target[i] = b.jump_PC;
            m_ctr[i]    = 2;
            m_ret[i]    = b.is_ret;
        end
`ifdef BP_RAS_EN
        if (b.is_call) begin
            m_ras.push_back(b.branch_ins_PC + 32'd8);
            if (m_ras.size() > D) void'(m_ras.pop_front());
        end else if (b.is_ret && m_ras.size() > 0) begin
            void'(m_ras.pop_back());
        end
`endif
    endfunction

    function automatic BRU_BP_bypass_t mk(input bit ex, input bit res, input logic [31:0] pc,
                                          input logic [31:0] jpc, input bit ret, input bit call);
        BRU_BP_bypass_t b;
        b.branch_in_exec = ex;
        b.branch_result  = res;
        b.branch_ins_PC  = pc;
        b.jump_PC        = jpc;
        b.is_ret         = ret;
        b.is_call        = call;
        return b;
    endfunction

    // One cycle: drive lookup + update, sample outputs at negedge (old state), then clock.
    task automatic tick(input logic [31:0] fpc, input BRU_BP_bypass_t b,
                        output logic t, output logic [31:0] p,
                        output logic et, output logic [31:0] ep);
        fetch_PC = fpc;
        bp       = b;
        @(negedge clk);
        t = predict_taken;
        p = predict_PC;
        model_predict(fpc, et, ep);
        @(posedge clk);
        model_update(b);
        #1;
    endtask

    task automatic test_reset();
        logic t, et;
        logic [31:0] p, ep;
        reset    = 1'b1;
        fetch_PC = PC_A;
        bp       = mk(1, 1, PC_A, 32'h8000_2000, 0, 0);
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;
        tick(32'hBFC0_0000, mk(0, 0, 0, 0, 0, 0), t, p, et, ep);
        n_cmp++;
        if (t !== 1'b0 || p !== 32'hBFC0_0008) begin
            n_err++;
            $display("FAIL reset_lookup: got taken=%b pc=%h, expected taken=0 pc=bfc00008", t, p);
        end
        tick(PC_A, mk(0, 0, 0, 0, 0, 0), t, p, et, ep);
        n_cmp++;
        if (t !== 1'b0 || p !== PC_A + 32'd8) begin
            n_err++;
            $display("FAIL reset_priority: got taken=%b pc=%h, expected taken=0 pc=%h", t, p, PC_A + 32'd8);
        end
    endtask

    task automatic test_alloc();
        logic t, et;
        logic [31:0] p, ep;
        tick(PC_A, mk(1, 1, PC_A, 32'h8000_2000, 0, 0), t, p, et, ep);
        n_cmp++;
        if (t !== 1'b0 || p !== PC_A + 32'd8) begin
            n_err++;
            $display("FAIL same_cycle_old: got taken=%b pc=%h, expected taken=0 pc=%h", t, p, PC_A + 32'd8);
        end
        tick(PC_A, mk(0, 0, 0, 0, 0, 0), t, p, et, ep);
        n_cmp++;
        if (t !== 1'b1 || p !== 32'h8000_2000) begin
            n_err++;
            $display("FAIL alloc_hit: got taken=%b pc=%h, expected taken=1 pc=80002000", t, p);
        end
    endtask

    task automatic test_alias();
        logic t, et;
        logic [31:0] p, ep;
        tick(PC_A, mk(1, 1, PC_B, 32'h8000_5000, 0, 0), t, p, et, ep);
        n_cmp++;
        if (t !== 1'b1 || p !== 32'h8000_2000) begin
            n_err++;
            $display("FAIL alias_old: got taken=%b pc=%h, expected taken=1 pc=80002000", t, p);
        end
        tick(PC_A, mk(0, 0, 0, 0, 0, 0), t, p, et, ep);
        n_cmp++;
        if (t !== 1'b0 || p !== PC_A + 32'd8) begin
            n_err++;
            $display("FAIL alias_miss: got taken=%b pc=%h, expected taken=0 pc=%h", t, p, PC_A + 32'd8);
        end
        tick(PC_B, mk(0, 0, 0, 0, 0, 0), t, p, et, ep);
        n_cmp++;
        if (t !== 1'b1 || p !== 32'h8000_5000) begin
            n_err++;
            $display("FAIL alias_new: got taken=%b pc=%h, expected taken=1 pc=80005000", t, p);
        end
    endtask

    task automatic test_counter();
        bit ex [12] = '{1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 0};
        bit rs [12] = '{1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        bit xt [12] = '{0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
        logic t, et;
        logic [31:0] p, ep, xp;
        for (int k = 0; k < 12; k++) begin
            tick(PC_A, mk(ex[k], rs[k], PC_A, 32'h8000_2000, 0, 0), t, p, et, ep);
            xp = xt[k] ? 32'h8000_2000 : PC_A + 32'd8;
            n_cmp++;
            if (t !== xt[k] || p !== xp) begin
                n_err++;
                $display("FAIL counter_step%0d: got taken=%b pc=%h, expected taken=%b pc=%h", k, t, p, xt[k], xp);
            end
        end
    endtask

    task automatic test_hold();
        logic t, et;
        logic [31:0] p, ep;
        for (int k = 0; k < 2; k++) begin
            tick(32'h8000_7000, mk(0, 1, 32'h8000_7000, 32'h8000_9999, k[0], 1), t, p, et, ep);
            n_cmp++;
            if (t !== 1'b0 || p !== 32'h8000_7008) begin
                n_err++;
                $display("FAIL hold%0d: got taken=%b pc=%h, expected taken=0 pc=80007008", k, t, p);
            end
        end
    endtask

`ifdef BP_RAS_EN
    task automatic test_ras();
        logic t, et;
        logic [31:0] p, ep, xp;
        tick(PC_R, mk(1, 1, PC_R, 32'h8000_9000, 1, 0), t, p, et, ep);
        tick(PC_R, mk(0, 0, 0, 0, 0, 0), t, p, et, ep);
        n_cmp++;
        if (t !== 1'b1 || p !== 32'h8000_9000) begin
            n_err++;
            $display("FAIL ras_empty_ret: got taken=%b pc=%h, expected taken=1 pc=80009000", t, p);
        end
        tick(PC_R, mk(1, 1, 32'h8000_0100, 32'h8000_3000, 0, 1), t, p, et, ep);
        tick(PC_R, mk(0, 0, 0, 0, 0, 0), t, p, et, ep);
        n_cmp++;
        if (t !== 1'b1 || p !== 32'h8000_0108) begin
            n_err++;
            $display("FAIL ras_call_ret: got taken=%b pc=%h, expected taken=1 pc=80000108", t, p);
        end
        for (int k = 0; k < 9; k++)
            tick(PC_R, mk(1, 1, 32'h8000_0200 + 32'(k * 32), 32'h8000_3000, 0, 1), t, p, et, ep);
        for (int j = 0; j < 8; j++) begin
            tick(PC_R, mk(1, 1, PC_R, 32'h8000_9000, 1, 0), t, p, et, ep);
            xp = 32'h8000_0208 + 32'((8 - j) * 32);
            n_cmp++;
            if (t !== 1'b1 || p !== xp) begin
                n_err++;
                $display("FAIL ras_pop%0d: got taken=%b pc=%h, expected taken=1 pc=%h", j, t, p, xp);
            end
        end
        for (int j = 0; j < 2; j++) begin
            tick(PC_R, mk(j == 0, 1, PC_R, 32'h8000_9000, 1, 0), t, p, et, ep);
            n_cmp++;
            if (t !== 1'b1 || p !== 32'h8000_9000) begin
                n_err++;
                $display("FAIL ras_drained%0d: got taken=%b pc=%h, expected taken=1 pc=80009000", j, t, p);
            end
        end
        tick(PC_R, mk(1, 1, 32'h8000_0600, 32'h8000_3000, 1, 1), t, p, et, ep);
        tick(PC_R, mk(0, 0, 0, 0, 0, 0), t, p, et, ep);
        n_cmp++;
        if (t !== 1'b1 || p !== 32'h8000_0608) begin
            n_err++;
            $display("FAIL ras_push_wins: got taken=%b pc=%h, expected taken=1 pc=80000608", t, p);
        end
    endtask
`else
    task automatic test_ret_plain();
        logic t, et;
        logic [31:0] p, ep;
        tick(PC_R, mk(1, 1, PC_R, 32'h8000_9000, 1, 0), t, p, et, ep);
        tick(PC_R, mk(1, 1, 32'h8000_0100, 32'h8000_3000, 0, 1), t, p, et, ep);
        tick(PC_R, mk(0, 0, 0, 0, 0, 0), t, p, et, ep);
        n_cmp++;
        if (t !== 1'b1 || p !== 32'h8000_9000) begin
            n_err++;
            $display("FAIL ret_as_jump: got taken=%b pc=%h, expected taken=1 pc=80009000", t, p);
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] bases [3] = '{32'h8000_0000, 32'h8001_0000, 32'h0040_0000};
        logic t, et;
        logic [31:0] p, ep, fpc, upc;
        BRU_BP_bypass_t b;
        for (int k = 0; k < 400; k++) begin
            fpc = bases[$urandom_range(2)] + 32'($urandom_range(7) * 4);
            upc = bases[$urandom_range(2)] + 32'($urandom_range(7) * 4);
            b   = mk($urandom_range(9) < 7, $urandom_range(1) == 1, upc, $urandom,
                     $urandom_range(7) == 0, $urandom_range(7) == 0);
            tick(fpc, b, t, p, et, ep);
            n_cmp++;
            if (t !== et || p !== ep) begin
                n_err++;
                $display("FAIL random%0d fetch=%h: got taken=%b pc=%h, expected taken=%b pc=%h",
                         k, fpc, t, p, et, ep);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        fetch_PC = '0;
        bp       = mk(0, 0, 0, 0, 0, 0);
        test_reset();
        test_alloc();
        test_alias();
        test_counter();
        test_hold();
`ifdef BP_RAS_EN
        test_ras();
`else
        test_ret_plain();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter BTB_ENTRIES, default 64, meaning number of direct-mapped BTB/BHT entries (power of 2).
REQ-002 SHALL have parameter RAS_DEPTH, default 8, meaning number of return-address-stack entries (power of 2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port fetch_PC  input  32  PC of the instruction being fetched (lookup key).
REQ-006 SHALL have port predict_taken  output  1  prediction that the instruction at fetch_PC is a taken branch/jump.
REQ-007 SHALL have port predict_PC  output  32  predicted target; equals fetch_PC+8 when predict_taken=0.
REQ-008 SHALL have port BRU_BP_bypass  input  BRU_BP_bypass_t  resolution from BRU: branch_in_exec, branch_result, branch_ins_PC, jump_PC, is_ret, is_call.

Function
REQ-009 SHALL index tables with fetch_PC[2+IDX-1:2], IDX=log2(BTB_ENTRIES); tag = remaining upper bits [31:2+IDX].
REQ-010 SHALL store per entry: valid, tag, target[31:0], ctr[1:0], is_ret.
REQ-011 SHALL perform lookup combinationally (zero latency): hit = valid && tag match.
REQ-012 SHALL drive predict_taken = hit && (ctr[1] || is_ret).
REQ-013 SHALL drive predict_PC = RAS top when hit && is_ret && RAS non-empty; else entry target when predict_taken; else fetch_PC+8.
REQ-014 SHALL update state only in a cycle with branch_in_exec=1, indexed by branch_ins_PC; new state visible to lookup from the next cycle (same-cycle read returns old contents).
REQ-015 On update hit: ctr saturating +1 if branch_result=1, -1 if 0 (limits 2'b00/2'b11); target <= jump_PC when branch_result=1; is_ret <= is_ret input.
REQ-016 On update miss with branch_result=1: allocate/overwrite entry with valid=1, new tag, target=jump_PC, ctr=2'b10, is_ret=is_ret input.
REQ-017 On update miss with branch_result=0: no table change.
REQ-018 RAS SHALL push branch_ins_PC+8 when branch_in_exec && is_call, and pop when branch_in_exec && is_ret.
REQ-019 RAS push when full SHALL overwrite oldest entry (circular pointer wraps, count saturates at RAS_DEPTH).
REQ-020 RAS pop when empty SHALL be ignored; count stays 0.
REQ-021 If is_call and is_ret both set in one update, push SHALL take precedence and no pop SHALL occur.
REQ-022 With branch_in_exec=0, all tables and RAS SHALL hold.

Reset
REQ-023 On reset, all valid bits SHALL clear, RAS count and pointer SHALL be 0; targets/tags need not clear.
REQ-024 After reset, predict_taken SHALL be 0 and predict_PC = fetch_PC+8 for any fetch_PC.
REQ-025 Reset SHALL take priority over a concurrent update in the same cycle.

Configuration
REQ-026 Macro BP_RAS_EN: when defined, RAS per REQ-018..021 is built and REQ-013 uses it.
REQ-027 Without BP_RAS_EN: no RAS storage; ret entries predict the stored BTB target as a normal jump.

Structure
REQ-028 BRU_BP_bypass_t SHALL remain in the shared package; the BTB entry struct and counter constants (WEAK_T=2'b10, etc.) SHALL be added there.
REQ-029 The RAS SHALL be a sub-module named ras (push/pop/top/empty ports), instantiated only under BP_RAS_EN.

Verification
REQ-030 Reset, fetch_PC=0xBFC00000 -> predict_taken=0, predict_PC=0xBFC00008.
REQ-031 Update branch_ins_PC=0x80001000, result=1, jump_PC=0x80002000; next cycle fetch 0x80001000 -> taken, predict_PC=0x80002000.
REQ-032 Same entry then two not-taken updates -> ctr 10->01->00, predict_taken=0; three taken updates -> ctr saturates 11.
REQ-033 Aliasing: update 0x80001000 then 0x80011000 (same index) taken -> fetch 0x80001000 misses.
REQ-034 Call at 0x80000100 then ret entry hit -> predict_PC=0x80000108; 9 calls (depth 8) then 8 pops drain the 8 most recent; further pop ignored.
REQ-035 Update and lookup same index same cycle -> lookup shows old value; new value next cycle.
